// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the core clock domain; decodes write/read frames
// (with auto-increment bursts) into one-cycle WR_REQ/RD_REQ pulses.
module spi_slave_sync #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int DUMMY       = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RSTN_async,
  input  logic          SCK,
  input  logic          CS_N,
  input  logic          MOSI,
  output logic          MISO,
  output logic          MISO_OE,
  output logic          WR_REQ,
  output logic          RD_REQ,
  output logic [AW-1:0] REQ_ADDR,
  output logic [DW-1:0] WR_DATA,
  input  logic [DW-1:0] RD_DATA,
  input  logic          RD_VALID,
  output logic          RD_ERR,
  output logic          FRAME_ERR,
  input  logic          ERR_CLR,
  output logic [2:0]    DBG_STATE
);

  localparam int   M1          = (AW > DW) ? AW : DW;
  localparam int   M2          = (M1 > DUMMY) ? M1 : DUMMY;
  localparam int   CW          = $clog2(M2 + 1);
  localparam logic ACTIVE_LVL  = (CPOL == 0);
  localparam logic SAMPLE_LEAD = (CPHA == 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_DATA   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_d, r_cs_d, r_samp, r_shft, r_mosi_s;
  logic [CW-1:0]          r_cnt;
  logic                   r_cmd0, r_is_read;
  logic [AW-1:0]          r_addr_sh, r_cur_addr;
  logic [DW-1:0]          r_data_sh, r_miso_sh, r_cap;
  logic                   r_cap_full, r_rd_pend;

  logic          w_sck, w_cs, w_mosi, w_edge, w_lead, w_sample, w_shift;
  logic [1:0]    w_cmd_next;
  logic [AW-1:0] w_addr_next;
  logic [DW-1:0] w_data_next;

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_edge      = w_sck ^ r_sck_d;
  assign w_lead      = (w_sck == ACTIVE_LVL);
  assign w_sample    = w_edge && (w_lead == SAMPLE_LEAD);
  assign w_shift     = w_edge && (w_lead != SAMPLE_LEAD);
  assign w_cmd_next  = {r_cmd0, r_mosi_s};
  assign w_addr_next = AW'({r_addr_sh, r_mosi_s});
  assign w_data_next = DW'({r_data_sh, r_mosi_s});
  assign MISO        = r_miso_sh[DW-1];
  assign DBG_STATE   = r_state;

  always_ff @(posedge CLK or negedge RSTN_async) begin
    if (!RSTN_async) begin
      r_state     <= S_IDLE;
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
      r_samp      <= 1'b0;
      r_shft      <= 1'b0;
      r_mosi_s    <= 1'b0;
      r_cnt       <= '0;
      r_cmd0      <= 1'b0;
      r_is_read   <= 1'b0;
      r_addr_sh   <= '0;
      r_cur_addr  <= '0;
      r_data_sh   <= '0;
      r_miso_sh   <= '0;
      r_cap       <= '0;
      r_cap_full  <= 1'b0;
      r_rd_pend   <= 1'b0;
      MISO_OE     <= 1'b0;
      WR_REQ      <= 1'b0;
      RD_REQ      <= 1'b0;
      REQ_ADDR    <= '0;
      WR_DATA     <= '0;
      RD_ERR      <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_N};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
      r_samp      <= w_sample;
      r_shft      <= w_shift;
      r_mosi_s    <= w_mosi;
      WR_REQ      <= 1'b0;
      RD_REQ      <= 1'b0;
      // Later assignments to the error flags win, so a set beats ERR_CLR.
      if (ERR_CLR) begin
        RD_ERR    <= 1'b0;
        FRAME_ERR <= 1'b0;
      end
      if (RD_VALID && r_rd_pend) begin
        r_cap      <= RD_DATA;
        r_cap_full <= 1'b1;
        r_rd_pend  <= 1'b0;
      end
      if (r_state == S_IDLE) begin
        if (r_cs_d && !w_cs) begin
          r_state <= S_CMD;
          r_cnt   <= '0;
        end
      end else if (w_cs) begin
        if (!(r_state == S_DATA && r_cnt == '0)) FRAME_ERR <= 1'b1;
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        MISO_OE    <= 1'b0;
        r_miso_sh  <= '0;
        r_cap_full <= 1'b0;
        r_rd_pend  <= 1'b0;
      end else if (r_samp) begin
        case (r_state)
          S_CMD: begin
            r_cmd0 <= r_mosi_s;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CW'(1)) begin
              r_cnt <= '0;
              case (w_cmd_next)
                2'b10:   begin r_state <= S_ADDR; r_is_read <= 1'b0; end
                2'b01:   begin r_state <= S_ADDR; r_is_read <= 1'b1; end
                default: r_state <= S_IGNORE;
              endcase
            end
          end
          S_ADDR: begin
            r_addr_sh <= w_addr_next;
            r_cnt     <= r_cnt + 1'b1;
            if (r_cnt == CW'(AW - 1)) begin
              r_cnt      <= '0;
              r_cur_addr <= w_addr_next;
              if (r_is_read) begin
                RD_REQ     <= 1'b1;
                REQ_ADDR   <= w_addr_next;
                r_rd_pend  <= 1'b1;
                r_cap_full <= 1'b0;
                r_state    <= (DUMMY > 0) ? S_DUMMY : S_DATA;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DUMMY: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(DUMMY - 1)) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_data_sh <= w_data_next;
            r_cnt     <= r_cnt + 1'b1;
            if (r_cnt == CW'(DW - 1)) begin
              r_cnt      <= '0;
              r_cur_addr <= r_cur_addr + 1'b1;
              if (!r_is_read) begin
                WR_REQ   <= 1'b1;
                REQ_ADDR <= r_cur_addr;
                WR_DATA  <= w_data_next;
              end
            end
          end
          default: ;
        endcase
      end else if (r_shft && r_state == S_DATA && r_is_read) begin
        // Word boundary: present the captured word and prefetch the next one.
        if (r_cnt == '0) begin
          MISO_OE   <= 1'b1;
          RD_REQ    <= 1'b1;
          REQ_ADDR  <= REQ_ADDR + 1'b1;
          r_rd_pend <= 1'b1;
          if (r_cap_full) begin
            r_miso_sh  <= r_cap;
            r_cap_full <= 1'b0;
          end else begin
            r_miso_sh <= '0;
            RD_ERR    <= 1'b1;
          end
        end else begin
          r_miso_sh <= r_miso_sh << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: three instances (modes 0, 1, 3) driven by a bit-banged
// SPI master; requests are checked against an expected queue by a monitor.
module tb_spi_slave_sync;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mosi, err_clr;
  logic [15:0] rd_data;
  logic        sck [3];
  logic        cs_n [3];
  logic        rd_valid [3];
  logic        miso [3];
  logic        miso_oe [3];
  logic        wr_req [3];
  logic        rd_req [3];
  logic [15:0] req_addr [3];
  logic [15:0] wr_data [3];
  logic        rd_err [3];
  logic        frame_err [3];
  logic [2:0]  dbg [3];

  int cpol_t [3] = '{0, 0, 1};
  int cpha_t [3] = '{0, 1, 1};

  logic [34:0]  exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           resp_en  = 1'b1;
  logic [127:0] rx_v, oe_v;
  logic [34:0]  mon_got;

  always #5 clk = ~clk;

  spi_slave_sync #(.CPOL(0), .CPHA(0)) u_m0 (
    .CLK(clk), .RSTN_async(rst_n), .SCK(sck[0]), .CS_N(cs_n[0]), .MOSI(mosi),
    .MISO(miso[0]), .MISO_OE(miso_oe[0]), .WR_REQ(wr_req[0]), .RD_REQ(rd_req[0]),
    .REQ_ADDR(req_addr[0]), .WR_DATA(wr_data[0]), .RD_DATA(rd_data), .RD_VALID(rd_valid[0]),
    .RD_ERR(rd_err[0]), .FRAME_ERR(frame_err[0]), .ERR_CLR(err_clr), .DBG_STATE(dbg[0]));
  spi_slave_sync #(.CPOL(0), .CPHA(1)) u_m1 (
    .CLK(clk), .RSTN_async(rst_n), .SCK(sck[1]), .CS_N(cs_n[1]), .MOSI(mosi),
    .MISO(miso[1]), .MISO_OE(miso_oe[1]), .WR_REQ(wr_req[1]), .RD_REQ(rd_req[1]),
    .REQ_ADDR(req_addr[1]), .WR_DATA(wr_data[1]), .RD_DATA(rd_data), .RD_VALID(rd_valid[1]),
    .RD_ERR(rd_err[1]), .FRAME_ERR(frame_err[1]), .ERR_CLR(err_clr), .DBG_STATE(dbg[1]));
  spi_slave_sync #(.CPOL(1), .CPHA(1)) u_m3 (
    .CLK(clk), .RSTN_async(rst_n), .SCK(sck[2]), .CS_N(cs_n[2]), .MOSI(mosi),
    .MISO(miso[2]), .MISO_OE(miso_oe[2]), .WR_REQ(wr_req[2]), .RD_REQ(rd_req[2]),
    .REQ_ADDR(req_addr[2]), .WR_DATA(wr_data[2]), .RD_DATA(rd_data), .RD_VALID(rd_valid[2]),
    .RD_ERR(rd_err[2]), .FRAME_ERR(frame_err[2]), .ERR_CLR(err_clr), .DBG_STATE(dbg[2]));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [34:0] ev(input int k, input logic w, input logic [15:0] a,
                                     input logic [15:0] d);
    return {k[1:0], w, a, d};
  endfunction

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hA5C3 : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [37:0] outs(input int k);
    return {miso[k], miso_oe[k], wr_req[k], rd_req[k], req_addr[k], wr_data[k],
            rd_err[k], frame_err[k]};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit-banged master: MSB of the nbits-wide frame first; MISO/OE captured just
  // before each sample edge.
  task automatic spi_xfer(input int k, input logic [127:0] tx, input int nbits,
                          input bit hold_cs, output logic [127:0] rx, output logic [127:0] oe);
    logic idle;
    idle = (cpol_t[k] != 0);
    rx = '0;
    oe = '0;
    cs_n[k] = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (cpha_t[k] == 0) begin
        mosi = tx[nbits-1-i];
        wait_clk(H);
        rx = {rx[126:0], miso[k]};
        oe = {oe[126:0], miso_oe[k]};
        sck[k] = ~idle;
        wait_clk(H);
        sck[k] = idle;
      end else begin
        sck[k] = ~idle;
        mosi = tx[nbits-1-i];
        wait_clk(H);
        rx = {rx[126:0], miso[k]};
        oe = {oe[126:0], miso_oe[k]};
        sck[k] = idle;
        wait_clk(H);
      end
    end
    if (!hold_cs) begin
      wait_clk(H);
      cs_n[k] = 1'b1;
      wait_clk(2 * H);
    end
  endtask

  // Responder: answers each RD_REQ two cycles later while enabled.
  initial begin
    logic [15:0] ra;
    int rk;
    bit go;
    go = 1'b0;
    rk = 0;
    ra = '0;
    rd_data = '0;
    for (int k = 0; k < 3; k++) rd_valid[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (rd_req[k] === 1'b1 && resp_en) begin
          rk = k;
          ra = req_addr[k];
          go = 1'b1;
        end
      if (go) begin
        go = 1'b0;
        wait_clk(2);
        rd_data = mem(ra);
        rd_valid[rk] = 1'b1;
        @(negedge clk);
        rd_valid[rk] = 1'b0;
      end
    end
  end

  // Monitor: every request pulse pops one expected entry.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (wr_req[k] === 1'b1 || rd_req[k] === 1'b1) begin
          chk("req_exclusive", 64'(wr_req[k] & rd_req[k]), 64'd0);
          mon_got = ev(k, wr_req[k], req_addr[k], wr_req[k] ? wr_data[k] : 16'h0);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL req_unexpected: got 0x%0h expected none", mon_got);
          end else begin
            chk("req", 64'(mon_got), 64'(exp_q.pop_front()));
          end
        end
    end
  end

  initial begin
    bit done;
    int seen;
    rst_n   = 1'b0;
    mosi    = 1'b0;
    err_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sck[k]  = (cpol_t[k] != 0);
      cs_n[k] = 1'b1;
    end
    wait_clk(5);
    for (int k = 0; k < 3; k++) begin
      chk("reset_outputs", 64'(outs(k)), 64'd0);
      chk("reset_state", 64'(dbg[k]), 64'd0);
    end
    rst_n = 1'b1;
    wait_clk(10);

    // Mode 0 single write.
    exp_q.push_back(ev(0, 1'b1, 16'h0012, 16'hBEEF));
    spi_xfer(0, {2'b10, 16'h0012, 16'hBEEF}, 34, 1'b0, rx_v, oe_v);
    chk("m0_wr_rd_err", 64'(rd_err[0]), 64'd0);
    chk("m0_wr_frame_err", 64'(frame_err[0]), 64'd0);

    // Mode 1 burst wrapping the address.
    exp_q.push_back(ev(1, 1'b1, 16'hFFFF, 16'h0001));
    exp_q.push_back(ev(1, 1'b1, 16'h0000, 16'h0002));
    exp_q.push_back(ev(1, 1'b1, 16'h0001, 16'h0003));
    spi_xfer(1, {2'b10, 16'hFFFF, 16'h0001, 16'h0002, 16'h0003}, 66, 1'b0, rx_v, oe_v);
    chk("m1_burst_frame_err", 64'(frame_err[1]), 64'd0);

    // Mode 3 read with timely data plus one prefetch.
    exp_q.push_back(ev(2, 1'b0, 16'h0040, 16'h0));
    exp_q.push_back(ev(2, 1'b0, 16'h0041, 16'h0));
    spi_xfer(2, {2'b01, 16'h0040, 4'h0, 16'h0}, 38, 1'b0, rx_v, oe_v);
    chk("m3_rd_miso", 64'(rx_v[15:0]), 64'hA5C3);
    chk("m3_rd_oe_data", 64'(oe_v[15:0]), 64'hFFFF);
    chk("m3_rd_oe_pre", 64'(oe_v[37:16]), 64'd0);
    chk("m3_rd_err", 64'(rd_err[2]), 64'd0);

    // Mode 0 read with no RD_VALID: zeros out, RD_ERR sticky.
    resp_en = 1'b0;
    exp_q.push_back(ev(0, 1'b0, 16'h0100, 16'h0));
    exp_q.push_back(ev(0, 1'b0, 16'h0101, 16'h0));
    exp_q.push_back(ev(0, 1'b0, 16'h0102, 16'h0));
    spi_xfer(0, {2'b01, 16'h0100, 4'h0, 16'h0}, 38, 1'b0, rx_v, oe_v);
    chk("m0_late_miso", 64'(rx_v[15:0]), 64'd0);
    chk("m0_late_oe", 64'(oe_v[15:0]), 64'hFFFF);
    chk("m0_late_rd_err", 64'(rd_err[0]), 64'd1);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(1);
    chk("m0_err_clr", 64'(rd_err[0]), 64'd0);

    // Late read again with ERR_CLR held until the cycle the error is set.
    exp_q.push_back(ev(0, 1'b0, 16'h0300, 16'h0));
    exp_q.push_back(ev(0, 1'b0, 16'h0301, 16'h0));
    exp_q.push_back(ev(0, 1'b0, 16'h0302, 16'h0));
    err_clr = 1'b1;
    done = 1'b0;
    seen = 0;
    fork
      spi_xfer(0, {2'b01, 16'h0300, 4'h0, 16'h0}, 38, 1'b0, rx_v, oe_v);
      begin
        for (int c = 0; c < 3000 && !done; c++) begin
          @(negedge clk);
          if (rd_req[0] === 1'b1) begin
            seen++;
            if (seen == 2) begin
              chk("m0_set_beats_clr", 64'(rd_err[0]), 64'd1);
              err_clr = 1'b0;
              done = 1'b1;
            end
          end
        end
        if (!done) begin
          n_checks++;
          $display("FAIL prefetch_timeout: got %0d requests expected 2", seen);
          err_clr = 1'b0;
        end
      end
    join
    chk("m0_late2_rd_err", 64'(rd_err[0]), 64'd1);
    resp_en = 1'b1;

    // Aborted write, then a clean write.
    spi_xfer(0, {2'b10, 16'h0055, 7'b1010101}, 25, 1'b0, rx_v, oe_v);
    chk("m0_abort_frame_err", 64'(frame_err[0]), 64'd1);
    exp_q.push_back(ev(0, 1'b1, 16'h0003, 16'h1234));
    spi_xfer(0, {2'b10, 16'h0003, 16'h1234}, 34, 1'b0, rx_v, oe_v);

    // Invalid command: nothing requested, MISO never enabled.
    spi_xfer(1, {2'b11, 16'h0033, 16'hFFFF}, 34, 1'b0, rx_v, oe_v);
    chk("m1_ignore_oe", 64'(oe_v[33:0]), 64'd0);

    // Reset in the middle of a mode 3 read data phase.
    exp_q.push_back(ev(2, 1'b0, 16'h0200, 16'h0));
    exp_q.push_back(ev(2, 1'b0, 16'h0201, 16'h0));
    spi_xfer(2, {2'b01, 16'h0200, 4'h0, 5'h0}, 27, 1'b1, rx_v, oe_v);
    wait_clk(4);
    chk("m3_pre_reset_oe", 64'(miso_oe[2]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("m3_reset_outputs", 64'(outs(2)), 64'd0);
    chk("m3_reset_state", 64'(dbg[2]), 64'd0);
    cs_n[2] = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    exp_q.push_back(ev(2, 1'b1, 16'h0007, 16'hC0DE));
    spi_xfer(2, {2'b10, 16'h0007, 16'hC0DE}, 34, 1'b0, rx_v, oe_v);
    chk("m3_post_rst_rd_err", 64'(rd_err[2]), 64'd0);
    chk("m3_post_rst_frame_err", 64'(frame_err[2]), 64'd0);

    wait_clk(50);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
